// File: rtl/or_accel_master_if.sv
// Bundle of the command, response and accelerator bus signals of or_accel_master.
// The master modport is the block's own view; slave is the surrounding environment.
interface or_accel_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_a_i;
    logic [31:0] cmd_b_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_data_o;
    logic        res_err_o;
    logic        acc_req_o;
    logic        acc_we_o;
    logic [3:0]  acc_be_o;
    logic [31:0] acc_addr_o;
    logic [31:0] acc_wdata_o;
    logic        acc_rvalid_i;
    logic [31:0] acc_rdata_i;

    modport master (
        input  cmd_valid_i, cmd_a_i, cmd_b_i, res_ready_i, acc_rvalid_i, acc_rdata_i,
        output cmd_ready_o, res_valid_o, res_data_o, res_err_o,
        output acc_req_o, acc_we_o, acc_be_o, acc_addr_o, acc_wdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_a_i, cmd_b_i, res_ready_i, acc_rvalid_i, acc_rdata_i,
        input  cmd_ready_o, res_valid_o, res_data_o, res_err_o,
        input  acc_req_o, acc_we_o, acc_be_o, acc_addr_o, acc_wdata_o
    );
endinterface

// File: rtl/or_accel_master.sv
// Bus initiator for the bitwise-OR accelerator: write A, write B, read A|B, return it.
// Optional per-wait timeout is built when OR_ACCEL_MASTER_TIMEOUT_EN is defined.
module or_accel_master #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] OFF_A       = 32'd0,
    parameter logic [31:0] OFF_B       = 32'd8,
    parameter logic [31:0] OFF_C       = 32'd16,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    or_accel_master_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_A   = 3'd1,
        S_WAIT_A = 3'd2,
        S_WR_B   = 3'd3,
        S_WAIT_B = 3'd4,
        S_RD_C   = 3'd5,
        S_WAIT_C = 3'd6,
        S_RESP   = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] res_q, res_d;
    logic        in_wait;

    logic        cmd_ready;
    logic        res_valid;
    logic        acc_req;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    assign in_wait = (state_q == S_WAIT_A) || (state_q == S_WAIT_B) || (state_q == S_WAIT_C);

`ifdef OR_ACCEL_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    // The counter holds the number of wait cycles already spent, so the
    // TIMEOUT_CYC-th wait cycle is the one that sees TIMEOUT_CYC-1.
    assign timeout_hit = in_wait && !bus.acc_rvalid_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, result and timeout registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_a_q <= '0;
            op_b_q <= '0;
            res_q  <= '0;
`ifdef OR_ACCEL_MASTER_TIMEOUT_EN
            cnt_q  <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            res_q  <= res_d;
`ifdef OR_ACCEL_MASTER_TIMEOUT_EN
            cnt_q  <= cnt_d;
            err_q  <= err_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    op_a_d  = bus.cmd_a_i;
                    op_b_d  = bus.cmd_b_i;
                    state_d = S_WR_A;
                end
            end
            S_WR_A:   state_d = S_WAIT_A;
            S_WAIT_A: if (bus.acc_rvalid_i) state_d = S_WR_B;
            S_WR_B:   state_d = S_WAIT_B;
            S_WAIT_B: if (bus.acc_rvalid_i) state_d = S_RD_C;
            S_RD_C:   state_d = S_WAIT_C;
            S_WAIT_C: begin
                if (bus.acc_rvalid_i) begin
                    res_d   = bus.acc_rdata_i;
                    state_d = S_RESP;
                end
            end
            S_RESP:   if (bus.res_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

`ifdef OR_ACCEL_MASTER_TIMEOUT_EN
        cnt_d = cnt_q;
        err_d = err_q;
        if (in_wait) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
        // An expired wait abandons the remaining bus transactions.
        if (timeout_hit) begin
            state_d = S_RESP;
            res_d   = '0;
            err_d   = 1'b1;
        end
        if ((state_q == S_RESP) && bus.res_ready_i) begin
            err_d = 1'b0;
        end
`endif
    end

    // Outputs decode from registered state only
    always_comb begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        acc_req   = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;

        case (state_q)
            S_IDLE: cmd_ready = 1'b1;
            S_WR_A: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = BASE_ADDR + OFF_A;
                acc_wdata = op_a_q;
            end
            S_WR_B: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = BASE_ADDR + OFF_B;
                acc_wdata = op_b_q;
            end
            S_RD_C: begin
                acc_req   = 1'b1;
                acc_addr  = BASE_ADDR + OFF_C;
            end
            S_RESP: res_valid = 1'b1;
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.res_valid_o = res_valid;
    assign bus.res_data_o  = res_q;
    assign bus.acc_req_o   = acc_req;
    assign bus.acc_we_o    = acc_we;
    assign bus.acc_be_o    = 4'hF;
    assign bus.acc_addr_o  = acc_addr;
    assign bus.acc_wdata_o = acc_wdata;
`ifdef OR_ACCEL_MASTER_TIMEOUT_EN
    assign bus.res_err_o   = err_q;
`else
    assign bus.res_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_or_accel_master.sv
// Directed and randomized bench for or_accel_master against a behavioural accelerator
// and an A|B reference; the timeout step is built only with OR_ACCEL_MASTER_TIMEOUT_EN.
module tb_or_accel_master;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] OFF_A = 32'd0;
    localparam logic [31:0] OFF_B = 32'd8;
    localparam logic [31:0] OFF_C = 32'd16;
    localparam int          TO    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    or_accel_master_if bus ();

    or_accel_master #(
        .BASE_ADDR  (BASE),
        .OFF_A      (OFF_A),
        .OFF_B      (OFF_B),
        .OFF_C      (OFF_C),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          viol     = 0;
    int          dly_a    = 0;
    int          dly_b    = 0;
    int          dly_c    = 0;
    bit          suppress_read = 1'b0;
    bit          spurious      = 1'b0;
    logic [31:0] mem_a = '0;
    logic [31:0] mem_b = '0;
    txn_t        log_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accelerator model: acts 2 time units after each edge, answers every request
    // 1+delay cycles later and returns the OR of the last two operand writes.
    initial begin
        int   cnt;
        bit   rd_pend;
        bit   outst;
        txn_t t;
        cnt = 0;
        rd_pend = 1'b0;
        outst = 1'b0;
        bus.acc_rvalid_i = 1'b0;
        bus.acc_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.acc_rvalid_i = 1'b0;
            bus.acc_rdata_i  = '0;
            if (rst) begin
                cnt = 0;
                outst = 1'b0;
                spurious = 1'b0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.acc_rvalid_i = 1'b1;
                        bus.acc_rdata_i  = rd_pend ? (mem_a | mem_b) : 32'h0;
                        outst = 1'b0;
                    end
                end
                if (spurious) begin
                    bus.acc_rvalid_i = 1'b1;
                    bus.acc_rdata_i  = 32'hDEAD_BEEF;
                    spurious = 1'b0;
                end
                if (bus.acc_req_o) begin
                    if (outst) viol++;
                    t.we    = bus.acc_we_o;
                    t.addr  = bus.acc_addr_o;
                    t.wdata = bus.acc_wdata_o;
                    t.be    = bus.acc_be_o;
                    log_q.push_back(t);
                    if (t.we && t.addr == BASE + OFF_A) mem_a = t.wdata;
                    if (t.we && t.addr == BASE + OFF_B) mem_b = t.wdata;
                    rd_pend = !t.we;
                    if (!t.we && suppress_read) begin
                        cnt = 0;
                    end else begin
                        outst = 1'b1;
                        cnt = 1 + ((t.addr == BASE + OFF_A) ? dly_a :
                                   (t.addr == BASE + OFF_B) ? dly_b : dly_c);
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (bus.cmd_ready_o !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("cmd_ready_wait", bus.cmd_ready_o, 1);
        log_q.delete();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_a_i     = a;
        bus.cmd_b_i     = b;
        step();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_a_i     = $urandom;
        bus.cmd_b_i     = $urandom;
        $display("cmd a=%08h b=%08h accepted", a, b);
    endtask

    task automatic finish_txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input int start_cyc, input int exp_lat, input int hold,
                              input bit exp_err, input bit spur);
        int          cyc;
        logic [31:0] exp_d;
        logic        exp_we[3];
        logic [31:0] exp_addr[3];
        logic [31:0] exp_wd[3];
        cyc = start_cyc;
        while (bus.res_valid_o !== 1'b1 && cyc < 400) begin
            step();
            cyc++;
        end
        exp_d = exp_err ? 32'h0 : (a | b);
        check({tag, "_valid"}, bus.res_valid_o, 1);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_data"}, bus.res_data_o, exp_d);
        check({tag, "_err"}, bus.res_err_o, exp_err);
        for (int i = 0; i < hold; i++) begin
            if (spur && i == 0) spurious = 1'b1;
            step();
            check({tag, "_hold_valid"}, bus.res_valid_o, 1);
            check({tag, "_hold_data"}, bus.res_data_o, exp_d);
            check({tag, "_hold_err"}, bus.res_err_o, exp_err);
            check({tag, "_hold_cmd_ready"}, bus.cmd_ready_o, 0);
        end
        bus.res_ready_i = 1'b1;
        step();
        bus.res_ready_i = 1'b0;
        check({tag, "_post_valid"}, bus.res_valid_o, 0);
        check({tag, "_post_cmd_ready"}, bus.cmd_ready_o, 1);
        check({tag, "_post_err"}, bus.res_err_o, 0);
        check({tag, "_post_req"}, bus.acc_req_o, 0);
        exp_we   = '{1'b1, 1'b1, 1'b0};
        exp_addr = '{BASE + OFF_A, BASE + OFF_B, BASE + OFF_C};
        exp_wd   = '{a, b, 32'h0};
        check({tag, "_bus_count"}, log_q.size(), 3);
        if (log_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check({tag, "_bus_we"}, log_q[i].we, exp_we[i]);
                check({tag, "_bus_addr"}, log_q[i].addr, exp_addr[i]);
                check({tag, "_bus_wdata"}, log_q[i].wdata, exp_wd[i]);
                check({tag, "_bus_be"}, log_q[i].be, 4'hF);
            end
        end
        $display("%s: result=%08h err=%0d latency=%0d hold=%0d", tag, bus.res_data_o, bus.res_err_o, cyc, hold);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, a2, b2, last;
        rst = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_a_i     = '0;
        bus.cmd_b_i     = '0;
        bus.res_ready_i = 1'b0;
        step();
        step();
        check("rst_cmd_ready", bus.cmd_ready_o, 1);
        check("rst_res_valid", bus.res_valid_o, 0);
        check("rst_res_err", bus.res_err_o, 0);
        check("rst_req", bus.acc_req_o, 0);
        check("rst_we", bus.acc_we_o, 0);
        check("rst_addr", bus.acc_addr_o, 0);
        check("rst_wdata", bus.acc_wdata_o, 0);
        check("rst_res_data", bus.res_data_o, 0);
        rst = 1'b0;
        step();

        // Basic transaction with the zero-wait responder
        send_cmd(32'h0000_00F0, 32'h0000_000F);
        finish_txn("basic", 32'h0000_00F0, 32'h0000_000F, 1, 7, 0, 1'b0, 1'b0);

        // Back-pressure on the response with a spurious rvalid while waiting
        a = $urandom;
        b = $urandom;
        send_cmd(a, b);
        finish_txn("backpressure", a, b, 1, 7, 5, 1'b0, 1'b1);
        last = a | b;

        // Spurious rvalid in IDLE
        spurious = 1'b1;
        step();
        check("spur_idle_cmd_ready", bus.cmd_ready_o, 1);
        check("spur_idle_res_valid", bus.res_valid_o, 0);
        check("spur_idle_data", bus.res_data_o, last);
        check("spur_idle_req", bus.acc_req_o, 0);
        step();
        check("spur_idle_cmd_ready2", bus.cmd_ready_o, 1);

        // Slow responder on the B write
        dly_b = 3;
        send_cmd(32'hA5A5_0000, 32'h0000_5A5A);
        finish_txn("slow_b", 32'hA5A5_0000, 32'h0000_5A5A, 1, 10, 0, 1'b0, 1'b0);
        dly_b = 0;

        // Command offered during WR_B is held off until IDLE
        a  = $urandom;
        b  = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        send_cmd(a, b);
        step();
        step();
        check("wrb_req", bus.acc_req_o, 1);
        check("wrb_addr", bus.acc_addr_o, BASE + OFF_B);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_a_i     = a2;
        bus.cmd_b_i     = b2;
        finish_txn("cmd_in_wrb", a, b, 3, 7, 2, 1'b0, 1'b0);
        log_q.delete();
        step();
        bus.cmd_valid_i = 1'b0;
        finish_txn("cmd_after_idle", a2, b2, 1, 7, 0, 1'b0, 1'b0);

        // Asynchronous reset in WAIT_B
        dly_b = 5;
        send_cmd($urandom, $urandom);
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        check("arst_cmd_ready", bus.cmd_ready_o, 1);
        check("arst_req", bus.acc_req_o, 0);
        check("arst_res_valid", bus.res_valid_o, 0);
        check("arst_res_data", bus.res_data_o, 0);
        step();
        rst = 1'b0;
        dly_b = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("arst_idle_req", bus.acc_req_o, 0);
            check("arst_idle_ready", bus.cmd_ready_o, 1);
        end
        a = $urandom;
        b = $urandom;
        send_cmd(a, b);
        finish_txn("after_reset", a, b, 1, 7, 0, 1'b0, 1'b0);

        // Randomized transactions with random responder delays and back-pressure
        for (int k = 0; k < 10; k++) begin
            int hold;
            dly_a = $urandom_range(0, 2);
            dly_b = $urandom_range(0, 2);
            dly_c = $urandom_range(0, 2);
            hold  = $urandom_range(0, 3);
            a = $urandom;
            b = $urandom;
            send_cmd(a, b);
            finish_txn("random", a, b, 1, 7 + dly_a + dly_b + dly_c, hold, 1'b0, 1'($urandom_range(0, 1)));
        end
        dly_a = 0;
        dly_b = 0;
        dly_c = 0;

`ifdef OR_ACCEL_MASTER_TIMEOUT_EN
        // Read response never arrives: error result after TO cycles of WAIT_C
        suppress_read = 1'b1;
        a = $urandom;
        b = $urandom;
        send_cmd(a, b);
        finish_txn("timeout", a, b, 1, 6 + TO, 2, 1'b1, 1'b0);
        suppress_read = 1'b0;
        a = $urandom;
        b = $urandom;
        send_cmd(a, b);
        finish_txn("post_timeout", a, b, 1, 7, 0, 1'b0, 1'b0);
`endif

        check("one_outstanding", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
